width_down_queue: RTL and testbench
===================================

# width_down_queue

Next-generation downsizing queue for the FIFO pipeline. It stores IN_WIDTH words and delivers them as RATIO = IN_WIDTH/OUT_WIDTH lanes of OUT_WIDTH on a valid/ready stream. RAM read latency is parameterised and absorbed by an internal prefetch buffer, so consumers never issue speculative reads or recover from them. Adds an occupancy count, a parametrised almost_full margin and a synchronous flush.

## Interface
- IN_WIDTH, 128, write word width; integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64, output lane width; RATIO = IN_WIDTH/OUT_WIDTH is a power of 2, >= 1.
- ADDR_WIDTH, 10, DEPTH = 2**ADDR_WIDTH words of IN_WIDTH.
- RAM_LATENCY, 2, read latency of the internal RAM in cycles, 1..3.
- AF_MARGIN, 4, almost_full asserts when count >= DEPTH - AF_MARGIN.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- in_valid  in  1  in_data is presented.
- in_data  in  IN_WIDTH  write word; lane k = in_data[(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH].
- in_ready  out  1  = !full.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the lane.
- out_data  out  OUT_WIDTH  current lane.
- out_last  out  1  current lane is lane RATIO-1 of its word.
- count  out  ADDR_WIDTH+1  words held and not fully drained.
- full, empty, almost_full  out  1  status: count==DEPTH, count==0, count>=DEPTH-AF_MARGIN.

## Operation
- Write: a word is accepted when in_valid && in_ready at an edge. It is stored at wr_ptr, and wr_ptr increments mod DEPTH.
- Lane order: lane 0 first, ascending. out_last is high on lane RATIO-1.
- Read engine: a RAM read at rd_ptr is issued when the RAM holds unread words and the number of words in flight plus words in the prefetch buffer is < RAM_LATENCY+1. This allows at most one issue per cycle.
- Prefetch buffer: RAM_LATENCY+1 words deep. The head word plus the lane counter drive out_data and out_last.
- Lane counter: log2(RATIO) bits. It advances on out_valid && out_ready. On the last lane it wraps to 0 and the head word pops.
- count: +1 on an accepted write; -1 on acceptance of the last lane; unchanged when both happen in the same cycle.
- full is based on count, which includes words in flight and in the buffer, so the RAM is never overwritten.
- flush: takes priority over all else in its cycle. It zeroes the pointers, count and lane counter, empties the buffer, and discards in-flight RAM returns. A write presented in the flush cycle is dropped.
- rst: has the same effect as flush, but asynchronous. Writes and reads while rst is high are ignored.
- Reset values: out_valid 0, out_last 0, count 0, empty 1, full 0, almost_full 0, in_ready 1. out_data is undefined until out_valid.

## Timing
- Write-to-read latency: the first word is accepted at edge T and out_valid rises after edge T+1+RAM_LATENCY. This is 3 cycles with defaults.
- Throughput: sustained 1 lane/cycle with out_ready held high, including across word boundaries, with no bubbles once the buffer is primed.
- Write throughput: 1 word/cycle while !full.
- Status outputs are derived from the registered count and are valid the cycle after the causing edge.
- in_ready drops in the cycle after the DEPTH-th word is accepted. It rises the cycle after the edge that accepts a last lane while count==DEPTH.
- out_valid and out_data hold stable while out_ready is low.
- Pointers wrap mod DEPTH without a gap. count never exceeds DEPTH.

## Test plan
- ADDR_WIDTH=4, defaults otherwise: write the single word 0x...0002_..._0001 (lane1=2, lane0=1), hold out_ready high. Required: out_valid at T+3, lanes 1 then 2, out_last on lane 2, count returns to 0.
- Write 16 words back-to-back. Required: full=1 and in_ready=0 after the 16th, almost_full=1 from count 12, and a 17th in_valid is not accepted.
- Simultaneous write and last-lane pop at count=5. Required: count stays 5 and empty=0.
- Stream 40 words with random in_valid and out_ready. Required: output lanes in order with no loss or duplication across pointer wrap, and full throughput when both sides are always active.
- Assert flush with 3 RAM reads in flight and a write presented. Required: next cycle count=0, empty=1, out_valid=0, no stale lane ever appears, and the dropped write is not stored.
- Assert rst asynchronously mid-burst, between edges. Required: outputs reach their reset values immediately, and operation resumes cleanly after deassertion.
- Sweep RAM_LATENCY 1..3. Required: the latency formula holds and sustained throughput stays at 1 lane/cycle.

Source files
------------

// File: rtl/width_down_queue.sv
// width_down_queue
// Downsizing queue: stores IN_WIDTH words in an internal RAM and streams each
// word out as RATIO = IN_WIDTH/OUT_WIDTH lanes of OUT_WIDTH, lane 0 first.
// A prefetch buffer of RAM_LATENCY+1 words absorbs the RAM read latency, so
// out_valid/out_data come straight from registered state.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   flush           synchronous clear of all contents (wins over everything)
//   in_valid/in_ready/in_data     write stream (in_ready = !full)
//   out_valid/out_ready/out_data  lane stream, out_last on lane RATIO-1
//   count           words held and not fully drained (RAM + in flight + buffer)
//   full/empty/almost_full        status derived from count
module width_down_queue #(
  parameter int IN_WIDTH    = 128,
  parameter int OUT_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 10,
  parameter int RAM_LATENCY = 2,
  parameter int AF_MARGIN   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [ADDR_WIDTH:0]  count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBUF   = RAM_LATENCY + 1;  // 2..4 entries

  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_LEVEL  = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(RATIO - 1);
  localparam logic [LANE_W-1:0]     LANE_ONE  = LANE_W'(1);
  localparam logic [1:0]            BUF_LAST  = 2'(NBUF - 1);
  localparam logic [3:0]            NBUF_C    = 4'(NBUF);

  // Storage
  logic [IN_WIDTH-1:0]   mem    [DEPTH];
  logic [IN_WIDTH-1:0]   rd_dat [RAM_LATENCY];
  logic [IN_WIDTH-1:0]   pf_mem [4];

  // Control state
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   unread;     // words in RAM not yet issued for read
  logic [RAM_LATENCY-1:0] rd_vld;    // one bit per read pipeline stage
  logic [1:0]            head, tail;
  logic [3:0]            pf_count;
  logic [LANE_W-1:0]     lane;

  logic       wr_en, fire, pop, ret, issue;
  logic [3:0] in_flight, occupancy;

  function automatic logic [1:0] buf_next(input logic [1:0] idx);
    return (idx == BUF_LAST) ? 2'd0 : idx + 2'd1;
  endfunction

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < RAM_LATENCY; i++)
      in_flight = in_flight + {3'b000, rd_vld[i]};
    wr_en = in_valid && !full && !flush;
    fire  = out_valid && out_ready && !flush;
    pop   = fire && (lane == LANE_LAST);
    ret   = rd_vld[RAM_LATENCY-1];
    // A word popping this cycle frees its slot at the same edge, so it is
    // credited here; occupancy after the edge still never exceeds NBUF.
    occupancy = in_flight + pf_count - {3'b000, pop};
    issue = (unread != '0) && (occupancy < NBUF_C) && !flush;
  end

  always_comb begin
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    almost_full = (count >= AF_LEVEL);
    in_ready    = !full;
    out_valid   = (pf_count != '0);
    out_data    = pf_mem[head][int'(lane)*OUT_WIDTH +: OUT_WIDTH];
    out_last    = out_valid && (lane == LANE_LAST);
  end

  // RAM, read pipeline data and prefetch data: no reset needed, validity is
  // tracked by the control registers below.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
    if (issue) rd_dat[0] <= mem[rd_ptr];
    for (int unsigned i = 1; i < RAM_LATENCY; i++)
      rd_dat[i] <= rd_dat[i-1];
    if (ret) pf_mem[tail] <= rd_dat[RAM_LATENCY-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      unread   <= '0;
      rd_vld   <= '0;
      head     <= '0;
      tail     <= '0;
      pf_count <= '0;
      lane     <= '0;
      count    <= '0;
    end else if (flush) begin
      // Clearing rd_vld discards any returns still in the read pipeline.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      unread   <= '0;
      rd_vld   <= '0;
      head     <= '0;
      tail     <= '0;
      pf_count <= '0;
      lane     <= '0;
      count    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;

      case ({wr_en, issue})
        2'b10:   unread <= unread + CNT_ONE;
        2'b01:   unread <= unread - CNT_ONE;
        default: ;
      endcase

      rd_vld[0] <= issue;
      for (int unsigned i = 1; i < RAM_LATENCY; i++)
        rd_vld[i] <= rd_vld[i-1];

      if (ret) tail <= buf_next(tail);
      if (pop) head <= buf_next(head);

      case ({ret, pop})
        2'b10:   pf_count <= pf_count + 4'd1;
        2'b01:   pf_count <= pf_count - 4'd1;
        default: ;
      endcase

      if (fire) lane <= (lane == LANE_LAST) ? '0 : lane + LANE_ONE;

      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_width_down_queue.sv
// Testbench for width_down_queue: three instances (RAM_LATENCY 1,2,3) share
// the stimulus; instance 1 (RAM_LATENCY 2) is the one fully checked.
module tb_width_down_queue;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NI    = 3;
  localparam int M     = 1;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [127:0] in_data;

  logic         in_ready    [NI];
  logic         out_valid   [NI];
  logic         out_last    [NI];
  logic         full        [NI];
  logic         empty       [NI];
  logic         almost_full [NI];
  logic [63:0]  out_data    [NI];
  logic [AW:0]  count       [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    width_down_queue #(
      .IN_WIDTH   (128),
      .OUT_WIDTH  (64),
      .ADDR_WIDTH (AW),
      .RAM_LATENCY(g + 1),
      .AF_MARGIN  (4)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready),
      .out_data   (out_data[g]),
      .out_last   (out_last[g]),
      .count      (count[g]),
      .full       (full[g]),
      .empty      (empty[g]),
      .almost_full(almost_full[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of stored words plus index of the lane on show.
  logic [127:0] mq[$];
  int           mlane    = 0;
  int           rx_lanes = 0;
  logic         acc_d;

  typedef struct {
    logic         iv;
    logic [127:0] d;
    logic         ordy;
    logic         ov;
    logic [63:0]  od;
    logic         last;
    logic [AW:0]  cnt;
    logic         full, empty, af, ir;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] lanev(int w, int l);
    return ((l == 0) ? 64'h1111_0000_0000_0000 : 64'h2222_0000_0000_0000) + 64'(w);
  endfunction

  function automatic logic [127:0] mkw(int w);
    return {lanev(w, 1), lanev(w, 0)};
  endfunction

  function automatic vec_t mkrow(logic iv, logic [127:0] d, logic ordy,
                                 logic ov, logic [63:0] od, logic last, int cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.od = od; v.last = last;
    v.cnt   = (AW+1)'(cnt);
    v.full  = (cnt == DEPTH);
    v.empty = (cnt == 0);
    v.af    = (cnt >= DEPTH - 4);
    v.ir    = (cnt < DEPTH);
    return v;
  endfunction

  task automatic check_row(int idx, vec_t v);
    logic bad;
    bad = (out_valid[M] !== v.ov) || (out_last[M] !== v.last) ||
          (count[M] !== v.cnt) || (full[M] !== v.full) || (empty[M] !== v.empty) ||
          (almost_full[M] !== v.af) || (in_ready[M] !== v.ir) ||
          (v.ov && (out_data[M] !== v.od));
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL table[%0d]: got ov=%b last=%b data=%h count=%0d full=%b empty=%b af=%b ir=%b; want ov=%b last=%b data=%h count=%0d full=%b empty=%b af=%b ir=%b",
               idx, out_valid[M], out_last[M], out_data[M], count[M], full[M], empty[M],
               almost_full[M], in_ready[M], v.ov, v.last, v.od, v.cnt, v.full, v.empty,
               v.af, v.ir);
    end
  endtask

  task automatic check_model(string tag);
    int           sz;
    logic [127:0] hw;
    logic [63:0]  el;
    logic         bad;
    sz = mq.size();
    hw = (sz > 0) ? mq[0] : '0;
    el = hw[mlane*64 +: 64];
    bad = (count[M] !== (AW+1)'(sz)) || (empty[M] !== (sz == 0)) ||
          (full[M] !== (sz == DEPTH)) || (almost_full[M] !== (sz >= DEPTH - 4)) ||
          (in_ready[M] !== (sz < DEPTH)) || $isunknown(out_valid[M]) ||
          (out_valid[M] && ((sz == 0) || (out_data[M] !== el) || (out_last[M] !== (mlane == 1)))) ||
          (!out_valid[M] && (out_last[M] !== 1'b0));
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got count=%0d ov=%b data=%h last=%b full=%b empty=%b af=%b ir=%b; want count=%0d data=%h last=%b",
               tag, count[M], out_valid[M], out_data[M], out_last[M], full[M], empty[M],
               almost_full[M], in_ready[M], sz, el, (mlane == 1));
    end
  endtask

  // One clock cycle: drive at the falling edge, update the model at the
  // rising edge, check at the next falling edge.
  task automatic step(input logic iv, input logic [127:0] d, input logic ordy,
                      input logic fl, output logic acc);
    logic fire;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    fire = out_valid[M] && ordy && !fl;
    acc  = iv && !fl && (mq.size() < DEPTH);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mlane = 0;
    end else begin
      if (fire) begin
        rx_lanes++;
        if (mlane == 1) begin
          if (mq.size() > 0) void'(mq.pop_front());
          mlane = 0;
        end else begin
          mlane++;
        end
      end
      if (acc) mq.push_back(d);
    end
    @(negedge clk);
    check_model(fl ? "flush_step" : "step");
  endtask

  task automatic drain(string tag, int budget);
    int guard;
    guard = 0;
    while ((mq.size() != 0) && (guard < budget)) begin
      step(1'b0, '0, 1'b1, 1'b0, acc_d);
      guard++;
    end
    n_vec++;
    if (mq.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: words left=%0d, required 0", tag, mq.size());
    end
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          guard;
    int          sent;
    logic [31:0] mask      [NI];
    int          lidx      [NI];
    int          bad_lanes [NI];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven directed vectors ----------------
    tbl.push_back(mkrow(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 0));            // reset state
    tbl.push_back(mkrow(1'b1, {64'd2, 64'd1}, 1'b1, 1'b0, '0, 1'b0, 1)); // edge T
    tbl.push_back(mkrow(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1));
    tbl.push_back(mkrow(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1));
    tbl.push_back(mkrow(1'b0, '0, 1'b1, 1'b1, 64'd1, 1'b0, 1));         // T+3
    tbl.push_back(mkrow(1'b0, '0, 1'b1, 1'b1, 64'd2, 1'b1, 1));
    tbl.push_back(mkrow(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 0));
    for (int i = 1; i <= DEPTH; i++)
      tbl.push_back(mkrow(1'b1, mkw(i - 1), 1'b0, (i >= 4), lanev(0, 0), 1'b0, i));
    tbl.push_back(mkrow(1'b1, mkw(99), 1'b0, 1'b1, lanev(0, 0), 1'b0, DEPTH)); // 17th refused
    for (int r = 1; r <= 2 * DEPTH; r++)
      tbl.push_back(mkrow(1'b0, '0, 1'b1, (r < 2 * DEPTH), lanev(r / 2, r % 2),
                          ((r % 2) == 1) && (r < 2 * DEPTH), DEPTH - r / 2));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      flush     = 1'b0;
      if (i == 0) begin
        check_row(i, tbl[i]);
      end else begin
        @(posedge clk);
        @(negedge clk);
        check_row(i, tbl[i]);
      end
    end

    // ---------------- write and last-lane pop together at count 5 ----------------
    for (int i = 0; i < 5; i++) step(1'b1, mkw(300 + i), 1'b0, 1'b0, acc_d);
    guard = 0;
    while (!out_valid[M] && guard < 10) begin
      step(1'b0, '0, 1'b0, 1'b0, acc_d);
      guard++;
    end
    step(1'b0, '0, 1'b1, 1'b0, acc_d);          // lane 0
    step(1'b1, mkw(305), 1'b1, 1'b0, acc_d);    // lane 1 pops while a word is written
    n_vec++;
    if (count[M] !== 5'd5 || empty[M] !== 1'b0) begin
      n_err++;
      $display("FAIL simul_wr_pop: count=%0d empty=%b, required count=5 empty=0", count[M], empty[M]);
    end
    drain("simul_drain", 40);

    // ---------------- random stream of 40 words ----------------
    base = rx_lanes;
    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 2000) begin
      step(($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 1) != 0), 1'b0, acc_d);
      if (acc_d) sent++;
      guard++;
    end
    drain("stream_drain", 300);
    n_vec++;
    if (rx_lanes - base != 80 || sent != 40) begin
      n_err++;
      $display("FAIL stream_lanes: lanes=%0d words=%0d, required lanes=80 words=40", rx_lanes - base, sent);
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b0, acc_d);

    // ---------------- flush with reads in flight and a write presented ----------------
    base = rx_lanes;
    for (int i = 0; i < 3; i++) step(1'b1, mkw(200 + i), 1'b0, 1'b0, acc_d);
    step(1'b1, mkw(203), 1'b0, 1'b1, acc_d);
    n_vec++;
    if (count[M] !== '0 || empty[M] !== 1'b1 || out_valid[M] !== 1'b0) begin
      n_err++;
      $display("FAIL flush_state: count=%0d empty=%b ov=%b, required 0 1 0", count[M], empty[M], out_valid[M]);
    end
    repeat (6) step(1'b0, '0, 1'b1, 1'b0, acc_d);   // stale returns would show here
    step(1'b1, mkw(204), 1'b1, 1'b0, acc_d);
    drain("flush_drain", 20);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, acc_d);
    n_vec++;
    if (rx_lanes - base != 2) begin
      n_err++;
      $display("FAIL flush_lanes: lanes=%0d, required 2", rx_lanes - base);
    end

    // ---------------- asynchronous reset mid-burst ----------------
    for (int i = 0; i < 3; i++) step(1'b1, mkw(400 + i), 1'b1, 1'b0, acc_d);
    in_valid = 1'b1; in_data = mkw(403); out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      n_vec++;
      if (out_valid[g] !== 1'b0 || out_last[g] !== 1'b0 || count[g] !== '0 || empty[g] !== 1'b1 ||
          full[g] !== 1'b0 || almost_full[g] !== 1'b0 || in_ready[g] !== 1'b1) begin
        n_err++;
        $display("FAIL async_rst[%0d]: ov=%b last=%b count=%0d empty=%b full=%b af=%b ir=%b, required 0 0 0 1 0 0 1",
                 g, out_valid[g], out_last[g], count[g], empty[g], full[g], almost_full[g], in_ready[g]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    mq.delete();
    mlane = 0;
    check_model("post_rst");

    // ---------------- latency and throughput, RAM_LATENCY 1..3 ----------------
    for (int g = 0; g < NI; g++) begin
      mask[g] = '0; lidx[g] = 0; bad_lanes[g] = 0;
    end
    for (int k = 0; k <= 30; k++) begin
      step((k < 6), mkw(500 + k), 1'b1, 1'b0, acc_d);
      for (int g = 0; g < NI; g++) begin
        mask[g][k] = out_valid[g];
        if (out_valid[g] === 1'b1) begin
          if (out_data[g] !== lanev(500 + lidx[g] / 2, lidx[g] % 2) ||
              out_last[g] !== ((lidx[g] % 2) == 1))
            bad_lanes[g]++;
          lidx[g]++;
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      logic [31:0] want;
      want = '0;
      for (int k = 0; k <= 30; k++) want[k] = (k >= g + 2) && (k <= g + 13);
      n_vec++;
      if (mask[g] !== want || bad_lanes[g] != 0) begin
        n_err++;
        $display("FAIL sweep_lat%0d: valid pattern=%h bad lanes=%0d, required pattern=%h bad lanes=0",
                 g + 1, mask[g], bad_lanes[g], want);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
